out_port_fifo: RTL and testbench

OUT_PORT_FIFO -- requirements
Module: out_port_fifo

---
 rtl/out_port_fifo.sv | 79 +++++++
 tb/tb_out_port_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_fifo.sv
// Output-port FIFO: captures the bus once per OutPort assertion and
// hands words to a valid/ready consumer in arrival order.
module out_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Clear,
  input  logic                   OutPort,
  input  logic [WIDTH-1:0]       BusMuxOut,
  input  logic                   ovf_clr,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             oe_q;
  logic             push_req, pop;
  logic             do_push, drop;

  assign push_req = OutPort & ~oe_q;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign pop      = ~empty & out_ready;
  // A full FIFO still accepts a push when a pop frees a slot that edge
  assign do_push  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (pop)     rd_d = rd_q + 1'b1;
    unique case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      oe_q  <= OutPort;
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_q] <= BusMuxOut;
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem_q[rd_q];
  assign count     = cnt_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: directed scenarios plus random traffic
// compared against a queue-based model of the FIFO.
module tb_out_port_fifo;
  localparam int W = 32;
  localparam int D = 4;

  logic          Clock = 1'b0;
  logic          Clear = 1'b0;
  logic          OutPort = 1'b0;
  logic [W-1:0]  BusMuxOut = '0;
  logic          ovf_clr = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          full, empty, overflow;
  logic [2:0]    count;
  logic [38:0]   act;

  int nvec = 0;
  int nerr = 0;

  logic [W-1:0] m_q[$];
  bit           m_ovf;
  bit           m_oe;
  logic [W-1:0] seen[$];

  out_port_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .Clock(Clock), .Clear(Clear), .OutPort(OutPort),
    .BusMuxOut(BusMuxOut), .ovf_clr(ovf_clr),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  always #5 Clock = ~Clock;

  assign act = {out_valid, out_data, full, empty, count, overflow};

  function automatic logic [38:0] expv();
    logic [W-1:0] h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    return {m_q.size() > 0, h, m_q.size() == D,
            m_q.size() == 0, 3'(m_q.size()), m_ovf};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_ovf = 0;
    m_oe  = 0;
    seen.delete();
  endtask

  task automatic tick(input logic op, input logic [W-1:0] d,
                      input logic rdy, input logic oc);
    bit push, pop, was_full;
    OutPort   = op;
    BusMuxOut = d;
    out_ready = rdy;
    ovf_clr   = oc;
    push      = op && !m_oe;
    pop       = rdy && (m_q.size() > 0);
    was_full  = (m_q.size() == D);
    if (pop) seen.push_back(out_data);
    if (oc) m_ovf = 0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!was_full || pop) m_q.push_back(d);
      else m_ovf = 1;
    end
    m_oe = op;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    OutPort = 0; out_ready = 0; ovf_clr = 0; BusMuxOut = '0;
    Clear = 0;
    model_clear();
    #2;
    Clear = 1;
  endtask

  task automatic test_reset();
    Clear = 0;
    model_clear();
    #3;
    nvec++;
    if (act !== expv()) begin
      nerr++;
      $display("FAIL reset_t3: got %h want %h", act, expv());
    end
    @(posedge Clock); #1;
    nvec++;
    if (act !== expv()) begin
      nerr++;
      $display("FAIL reset_edge: got %h want %h", act, expv());
    end
    Clear = 1;
  endtask

  task automatic test_single_push();
    do_reset();
    tick(1, 32'h0000_00A5, 0, 0);
    tick(1, 32'h0000_00A5, 0, 0);
    tick(0, 32'h0, 0, 0);
    nvec++;
    if (act !== expv() || count !== 3'd1 || out_data !== 32'hA5) begin
      nerr++;
      $display("FAIL single_push: got %h want %h", act, expv());
    end
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] want[4];
    want = '{1, 2, 3, 4};
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      tick(1, W'(v), 0, 0);
      tick(0, 0, 0, 0);
    end
    nvec++;
    if (act !== expv() || !full || count !== 3'd4 || !overflow) begin
      nerr++;
      $display("FAIL fill_ovf: got %h want %h", act, expv());
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);
    nvec++;
    if (seen.size() != 4 || act !== expv() || !empty) begin
      nerr++;
      $display("FAIL fill_drain_n: got %0d want 4", seen.size());
    end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      nvec++;
      if (seen[i] !== want[i]) begin
        nerr++;
        $display("FAIL fill_order[%0d]: got %h want %h", i, seen[i], want[i]);
      end
    end
  endtask

  task automatic test_full_pop();
    logic [W-1:0] want[4];
    want = '{2, 3, 4, 6};
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      tick(1, W'(v), 0, 0);
      tick(0, 0, 0, 0);
    end
    tick(1, 32'd6, 1, 0);
    nvec++;
    if (act !== expv() || count !== 3'd4 || overflow !== 1'b0) begin
      nerr++;
      $display("FAIL full_pop: got %h want %h", act, expv());
    end
    seen.delete();
    tick(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (i >= seen.size() || seen[i] !== want[i]) begin
        nerr++;
        $display("FAIL full_pop_order[%0d]: got %h want %h", i,
                 (i < seen.size()) ? seen[i] : 'x, want[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int v = 10; v <= 19; v++) begin
      tick(1, W'(v), 1, 0);
      tick(0, 0, 1, 0);
    end
    for (int i = 0; i < 10; i++) begin
      nvec++;
      if (i >= seen.size() || seen[i] !== W'(10 + i)) begin
        nerr++;
        $display("FAIL wrap[%0d]: got %h want %h", i,
                 (i < seen.size()) ? seen[i] : 'x, 10 + i);
      end
    end
    nvec++;
    if (act !== expv() || count !== 3'd0 || !empty) begin
      nerr++;
      $display("FAIL wrap_end: got %h want %h", act, expv());
    end
  endtask

  task automatic test_ovf_priority();
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      tick(1, W'(v + 32), 0, 0);
      tick(0, 0, 0, 0);
    end
    tick(1, 32'd99, 0, 1);
    nvec++;
    if (act !== expv() || overflow !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_set_wins: got %h want %h", act, expv());
    end
    tick(0, 0, 0, 1);
    nvec++;
    if (act !== expv() || overflow !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_clr: got %h want %h", act, expv());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int v = 1; v <= 3; v++) begin
      tick(1, W'(v * 7), 0, 0);
      tick(0, 0, 0, 0);
    end
    OutPort = 1;
    BusMuxOut = 32'h77;
    #2;
    Clear = 0;
    m_q.delete();
    m_ovf = 0;
    m_oe = 0;
    #1;
    nvec++;
    if (act !== expv() || out_valid || out_data !== '0 || count !== 0) begin
      nerr++;
      $display("FAIL reset_mid: got %h want %h", act, expv());
    end
    #1;
    Clear = 1;
    tick(1, 32'h77, 0, 0);
    tick(1, 32'h78, 0, 0);
    nvec++;
    if (act !== expv() || count !== 3'd1 || out_data !== 32'h77) begin
      nerr++;
      $display("FAIL reset_oe_push: got %h want %h", act, expv());
    end
  endtask

  task automatic test_random();
    logic op, rdy, oc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      op  = 1'($urandom_range(0, 1));
      rdy = (i < 200) ? ($urandom_range(0, 3) == 0)
                      : ($urandom_range(0, 3) != 0);
      oc  = ($urandom_range(0, 15) == 0);
      tick(op, $urandom, rdy, oc);
      nvec++;
      if (act !== expv()) begin
        nerr++;
        $display("FAIL random[%0d]: got %h want %h", i, act, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_pop();
    test_wrap();
    test_ovf_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
